muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural LO/HI registers, the next generation of the single-cycle multiplier and special-register pair in the MIPS datapath. It performs signed/unsigned multiply and divide on WIDTH-bit operands over WIDTH+1 cycles using one shared shift/add datapath, and holds the 2×WIDTH result in LO/HI for MFLO/MFHI. Control stalls on `busy`. MTLO/MTHI-style direct writes are supported while idle.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit                                                              |
// | Iterative signed/unsigned multiply/divide with LO/HI result registers.   |
// | Define MULDIV_DIV_EN to build the divider; otherwise op[1] is ignored.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic [WIDTH-1:0] wrdata,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mq;
   logic [WIDTH-1:0]   r_m;
   logic               r_neg_lo;
   logic               r_neg_hi;
   logic               r_div;
   logic               r_divzero_case;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_lhs;
   logic [WIDTH:0]     w_rhs;
   logic               w_cin;
   logic [WIDTH+1:0]   w_sum;

`ifndef MULDIV_DIV_EN
   logic w_unused_op1;
   assign w_unused_op1   = op[1];
   assign r_div          = 1'b0;
   assign r_divzero_case = 1'b0;
`endif

   assign w_neg_a = op[0] & a[WIDTH-1];
   assign w_neg_b = op[0] & b[WIDTH-1];
   assign w_mag_a = w_neg_a ? -a : a;
   assign w_mag_b = w_neg_b ? -b : b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      busy         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_CALC;
         S_CALC:  if (r_count == c_last_step) w_next_state = S_FIX;
         S_FIX:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // One adder: acc + m for multiply, {rem,next bit} - m for divide.
   // For divide, bit WIDTH+1 of the sum is the no-borrow (quotient) bit.
   always_comb begin
      w_lhs = {1'b0, r_acc};
      w_rhs = {1'b0, r_m};
      w_cin = 1'b0;
      if (r_div) begin
         w_lhs = {r_acc, r_mq[WIDTH-1]};
         w_rhs = ~{1'b0, r_m};
         w_cin = 1'b1;
      end
   end

   assign w_sum = {1'b0, w_lhs} + {1'b0, w_rhs} + {{(WIDTH+1){1'b0}}, w_cin};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lo       <= '0;
         hi       <= '0;
         done     <= 1'b0;
         divzero  <= 1'b0;
         r_count  <= '0;
         r_acc    <= '0;
         r_mq     <= '0;
         r_m      <= '0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_div          <= 1'b0;
         r_divzero_case <= 1'b0;
`endif
      end else begin
         done    <= 1'b0;
         divzero <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (wr_lo) lo <= wrdata;
               if (wr_hi) hi <= wrdata;
               if (start) begin
                  r_count  <= '0;
                  r_acc    <= '0;
                  r_mq     <= w_mag_a;
                  r_m      <= w_mag_b;
                  r_neg_lo <= w_neg_a ^ w_neg_b;
                  r_neg_hi <= w_neg_a;
`ifdef MULDIV_DIV_EN
                  r_div          <= op[1];
                  r_divzero_case <= op[1] & (b == '0);
`endif
               end
            end
            S_CALC: begin
               r_count <= r_count + 1'b1;
               if (r_div) begin
                  r_acc <= w_sum[WIDTH+1] ? w_sum[WIDTH-1:0] : w_lhs[WIDTH-1:0];
                  r_mq  <= {r_mq[WIDTH-2:0], w_sum[WIDTH+1]};
               end else if (r_mq[0]) begin
                  {r_acc, r_mq} <= {w_sum[WIDTH:0], r_mq[WIDTH-1:1]};
               end else begin
                  {r_acc, r_mq} <= {1'b0, r_acc, r_mq[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               done    <= 1'b1;
               divzero <= r_divzero_case;
               if (r_div) begin
                  // Divide by zero leaves |a| in the remainder, so the sign fix restores a.
                  lo <= r_divzero_case ? '1 : (r_neg_lo ? -r_mq : r_mq);
                  hi <= r_neg_hi ? -r_acc : r_acc;
               end else begin
                  {hi, lo} <= r_neg_lo ? -{r_acc, r_mq} : {r_acc, r_mq};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_unit                                                           |
// | Vector table, randomized ops against an arithmetic model, corner cases.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct {
      logic [1:0]  vop;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] elo;
      logic [31:0] ehi;
      logic        edz;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, start, wr_lo, wr_hi;
   logic [1:0]  op;
   logic [W-1:0] a, b, wrdata, lo, hi;
   logic        busy, done, divzero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wr_lo(wr_lo), .wr_hi(wr_hi), .wrdata(wrdata),
      .busy(busy), .done(done), .divzero(divzero), .lo(lo), .hi(hi)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic from the architectural rules.
   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] ml, output logic [31:0] mh, output logic mdz);
      longint      sx, sy, q, r;
      logic [63:0] p;
      logic [1:0]  eo;
      eo  = o;
      if (!DIV_EN) eo[1] = 1'b0;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      mdz = 1'b0;
      ml  = '0;
      mh  = '0;
      case (eo)
         2'b00: begin p = {32'h0, x} * {32'h0, y}; ml = p[31:0]; mh = p[63:32]; end
         2'b01: begin p = sx * sy; ml = p[31:0]; mh = p[63:32]; end
         2'b10: begin
            if (y == 0) begin ml = '1; mh = x; mdz = 1'b1; end
            else begin ml = x / y; mh = x % y; end
         end
         default: begin
            if (y == 0) begin ml = '1; mh = x; mdz = 1'b1; end
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin ml = x; mh = '0; end
            else begin q = sx / sy; r = sx % sy; ml = q[31:0]; mh = r[31:0]; end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return $urandom_range(1, 20);
         default: return $urandom;
      endcase
   endfunction

   // Caller is just after an edge; start is accepted at the next edge (E0).
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(input logic [31:0] pl, input logic [31:0] ph, output int lat,
                            output int bcnt, output logic [31:0] l, output logic [31:0] h,
                            output logic dz, output int bad);
      lat = 0; bcnt = 0; bad = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         if (divzero) bad++;
         if (lo !== pl || hi !== ph) bad++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy) bad++;
      l = lo; h = hi; dz = divzero;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl[$];
      logic [31:0] rl, rh, el, eh, pl, ph, x, y;
      logic        rdz, edz;
      logic [1:0]  o;
      int          lat, bcnt, bad, ndone;

      reset = 1'b0; start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
      op = 2'b00; a = '0; b = '0; wrdata = '0;

      tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0});
      tbl.push_back('{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0});
      tbl.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0});
`ifdef MULDIV_DIV_EN
      tbl.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
      tbl.push_back('{2'b10, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0});
      tbl.push_back('{2'b10, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1});
      tbl.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0});
      tbl.push_back('{2'b11, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0});
      tbl.push_back('{2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
`else
      tbl.push_back('{2'b11, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0});
      tbl.push_back('{2'b10, 32'd100,       32'd7,         32'h0000_02BC, 32'h0,         1'b0});
`endif

      repeat (3) @(posedge clk);
      #1;
      check("reset_flags", {61'h0, busy, done, divzero}, 64'h0);
      check("reset_lohi", {hi, lo}, 64'h0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Back-to-back: each op starts in the previous op's done cycle.
      foreach (tbl[i]) begin
         pl = lo; ph = hi;
         launch(tbl[i].vop, tbl[i].va, tbl[i].vb);
         wait_done(pl, ph, lat, bcnt, rl, rh, rdz, bad);
         check($sformatf("vec%0d_lo", i), rl, tbl[i].elo);
         check($sformatf("vec%0d_hi", i), rh, tbl[i].ehi);
         check($sformatf("vec%0d_divzero", i), rdz, tbl[i].edz);
         check($sformatf("vec%0d_latency", i), lat, LAT);
         check($sformatf("vec%0d_busy_cycles", i), bcnt, LAT);
         check($sformatf("vec%0d_hold_and_stray", i), bad, 0);
      end

      for (int n = 0; n < 60; n++) begin
         o = 2'($urandom_range(0, 3)); x = pick(); y = pick();
         model(o, x, y, el, eh, edz);
         pl = lo; ph = hi;
         launch(o, x, y);
         wait_done(pl, ph, lat, bcnt, rl, rh, rdz, bad);
         check($sformatf("rnd%0d_op%0d_lo", n, o), rl, el);
         check($sformatf("rnd%0d_op%0d_hi", n, o), rh, eh);
         check($sformatf("rnd%0d_divzero", n), rdz, edz);
         check($sformatf("rnd%0d_timing", n), {lat[15:0], bcnt[15:0], bad[15:0]},
               {16'(LAT), 16'(LAT), 16'h0});
      end

      // Inputs while busy are ignored; then a start in the done cycle.
      pl = lo; ph = hi;
      launch(2'b00, 32'd6, 32'd7);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; wr_lo = 1'b1; wrdata = 32'hDEAD;
      @(posedge clk); #1;
      start = 1'b0; wr_lo = 1'b0; a = 32'd1234; b = 32'd5678;
      wait_done(pl, ph, lat, bcnt, rl, rh, rdz, bad);
      check("busy_ignore_result", {rh, rl}, 64'd42);
      check("busy_ignore_latency", lat, LAT - 5);
      check("busy_ignore_hold", bad, 0);
      pl = lo; ph = hi;
      launch(2'b00, 32'd3, 32'd5);
      wait_done(pl, ph, lat, bcnt, rl, rh, rdz, bad);
      check("done_cycle_start_result", {rh, rl}, 64'd15);
      check("done_cycle_start_latency", lat, LAT);
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("no_extra_done", ndone, 0);

      // Asynchronous reset in the middle of an operation.
      launch(2'b00, 32'h0000_FFFF, 32'h0000_FFFF);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midop_reset_flags", {61'h0, busy, done, divzero}, 64'h0);
      check("midop_reset_lohi", {hi, lo}, 64'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      ndone = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check("midop_reset_no_done", ndone, 0);
      launch(2'b00, 32'd2, 32'd3);
      wait_done(32'h0, 32'h0, lat, bcnt, rl, rh, rdz, bad);
      check("after_reset_result", {rh, rl}, 64'd6);
      check("after_reset_latency", lat, LAT);

      // Direct writes while idle.
      wr_hi = 1'b1; wrdata = 32'h1234_5678;
      @(posedge clk); #1;
      wr_hi = 1'b0;
      check("wr_hi_only", {hi, lo}, {32'h1234_5678, 32'd6});
      wr_lo = 1'b1; wr_hi = 1'b1; wrdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      wr_lo = 1'b0; wr_hi = 1'b0;
      check("wr_both", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
      wr_lo = 1'b1; wrdata = 32'hCAFE_F00D;
      launch(2'b00, 32'd9, 32'd9);
      wr_lo = 1'b0;
      check("wr_with_start", {hi, lo}, {32'hA5A5_A5A5, 32'hCAFE_F00D});
      wait_done(32'hCAFE_F00D, 32'hA5A5_A5A5, lat, bcnt, rl, rh, rdz, bad);
      check("wr_with_start_result", {rh, rl}, 64'd81);
      check("wr_with_start_hold", bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
